// File: rtl/imm_pack_pkg.sv
// imm_pack_pkg: immediate field kinds, widths and the fit test shared by packer and sign-extender
package imm_pack_pkg;
  localparam logic [1:0] KIND_BR = 2'd0;
  localparam logic [1:0] KIND_LS = 2'd1;
  localparam logic [1:0] KIND_ALU = 2'd2;
  localparam logic [1:0] KIND_RSV = 2'd3;
  localparam int FIELD_W = 24;
  localparam int BR_W = 24;
  localparam int LS_W = 12;
  localparam int ALU_W = 8;
  typedef struct packed {
    logic [FIELD_W-1:0] field;
    logic fit;
    logic [1:0] kind;
  } beat_t;
  // true when v[31:lsb] are all copies of the sign bit
  function automatic logic fits(input logic [31:0] v, input int lsb);
    logic [31:0] t;
    t = $signed(v) >>> lsb;
    return &t | ~|t;
  endfunction
endpackage

// File: rtl/imm_pack_core.sv
// imm_pack_core: combinational (kind, value) -> (field, fit) immediate packer
module imm_pack_core
  import imm_pack_pkg::*;
(
  input  logic [1:0]         kind,
  input  logic [31:0]        value,
  output logic [FIELD_W-1:0] field,
  output logic               fit
);
  logic s;
  assign s = value[31];
  always_comb begin
    field = kind == KIND_BR ? value[FIELD_W-1:0] :
            kind == KIND_LS ? {{(FIELD_W-LS_W){s}}, value[LS_W-1:0]} :
            kind == KIND_ALU ? {{(FIELD_W-ALU_W){s}}, value[ALU_W-1:0]} : '0;
    fit = kind == KIND_BR ? fits(value, BR_W-1) :
          kind == KIND_LS ? fits(value, LS_W) :
          kind == KIND_ALU ? fits(value, ALU_W) : 1'b0;
  end
endmodule

// File: rtl/imm_pack.sv
// imm_pack: streaming immediate packer with output register, skid buffer and misfit counter
module imm_pack
  import imm_pack_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_kind,
  input  logic [31:0]         in_value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FIELD_W-1:0]  out_field,
  output logic                out_fit,
  output logic [1:0]          out_kind,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    misfit_cnt
);
  logic [FIELD_W-1:0] core_field;
  logic core_fit;
  beat_t in_beat, out_q, skid_q;
  logic skid_valid;
  logic acc, load_out;
  imm_pack_core u_core (
    .kind(in_kind),
    .value(in_value),
    .field(core_field),
    .fit(core_fit)
  );
  assign in_beat = '{field: core_field, fit: core_fit, kind: in_kind};
  assign acc = in_valid & in_ready;
  assign load_out = !out_valid | out_ready;
  assign out_field = out_q.field;
  assign out_fit = out_q.fit;
  assign out_kind = out_q.kind;
  // skid can only be full while in_ready is low, so a drain never coincides with skid + new beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
      skid_valid <= 1'b0;
      in_ready <= 1'b1;
      misfit_cnt <= '0;
    end else begin
      if (load_out) begin
        out_valid <= skid_valid | acc;
        if (skid_valid) out_q <= skid_q;
        else if (acc) out_q <= in_beat;
        skid_valid <= 1'b0;
        in_ready <= 1'b1;
      end else if (acc) begin
        skid_q <= in_beat;
        skid_valid <= 1'b1;
        in_ready <= 1'b0;
      end
      misfit_cnt <= cnt_clr ? '0 :
                    (acc & !in_beat.fit & ~&misfit_cnt) ? misfit_cnt + 1'b1 : misfit_cnt;
    end
  end
endmodule

// File: tb/tb_imm_pack.sv
// tb_imm_pack: randomized scoreboard bench for imm_pack against a range-based reference model
module tb_imm_pack;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_fit, cnt_clr;
  logic [1:0] in_kind, out_kind;
  logic [31:0] in_value;
  logic [23:0] out_field;
  logic [CW-1:0] misfit_cnt;
  typedef struct {
    logic [1:0] kind;
    logic [31:0] value;
    logic [23:0] field;
    logic fit;
  } exp_t;
  exp_t q[$];
  exp_t ea, em;
  int checks = 0, errors = 0, exp_cnt = 0;
  bit run = 0, soak = 0, held = 0, acc;
  logic [23:0] h_field;
  logic h_fit;
  logic [1:0] h_kind;

  imm_pack #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_value(in_value), .out_valid(out_valid),
    .out_ready(out_ready), .out_field(out_field), .out_fit(out_fit),
    .out_kind(out_kind), .cnt_clr(cnt_clr), .misfit_cnt(misfit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // value must lie in the signed range the decoder can reproduce for that kind
  function automatic exp_t model(input logic [1:0] k, input logic [31:0] v);
    exp_t e;
    longint sv, lim, f;
    sv = longint'($signed(v));
    case (k)
      2'd0: begin lim = 64'd1 << 23; f = sv & 64'hFFFFFF; end
      2'd1: begin lim = 64'd4096; f = (sv < 0 ? 64'hFFF000 : 64'd0) | (sv & 64'hFFF); end
      2'd2: begin lim = 64'd256; f = (sv < 0 ? 64'hFFFF00 : 64'd0) | (sv & 64'hFF); end
      default: begin lim = 0; f = 0; end
    endcase
    e.kind = k;
    e.value = v;
    e.field = f[23:0];
    e.fit = (sv >= -lim) && (sv < lim);
    return e;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      chk("misfit_cnt", longint'(misfit_cnt), exp_cnt);
      chk("in_ready", longint'(in_ready), longint'(q.size() < 2));
      chk("out_valid", longint'(out_valid), longint'(q.size() > 0));
      if (rst) begin
        q.delete();
        exp_cnt = 0;
      end else begin
        acc = in_valid && in_ready;
        if (acc) begin
          ea = model(in_kind, in_value);
          q.push_back(ea);
        end
        if (cnt_clr) exp_cnt = 0;
        else if (acc && !ea.fit && exp_cnt < CMAX) exp_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (run && !rst) begin
      if (held) begin
        chk("stable_field", longint'(out_field), longint'(h_field));
        chk("stable_fit", longint'(out_fit), longint'(h_fit));
        chk("stable_kind", longint'(out_kind), longint'(h_kind));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: field %0h with empty scoreboard at %0t", out_field, $time);
        end else begin
          em = q.pop_front();
          chk("field", longint'(out_field), longint'(em.field));
          chk("fit", longint'(out_fit), longint'(em.fit));
          chk("kind", longint'(out_kind), longint'(em.kind));
          if (out_fit) chk("roundtrip", longint'($signed(out_field)), longint'($signed(em.value)));
        end
      end
      held = out_valid && !out_ready;
      h_field = out_field;
      h_fit = out_fit;
      h_kind = out_kind;
    end else held = 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (soak) out_ready = 1'($urandom_range(1));
  endtask

  task automatic send(input logic [1:0] k, input logic [31:0] v);
    bit a;
    int n = 0;
    in_valid = 1'b1;
    in_kind = k;
    in_value = v;
    do begin
      @(negedge clk);
      a = in_ready;
      step();
      n++;
    end while (!a && n < 200);
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: kind %0d value %0h not accepted", k, v);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  function automatic logic [31:0] rand_value();
    int base;
    case ($urandom_range(3))
      0: return $urandom;
      1: return 32'(int'($urandom_range(600)) - 300);
      2: base = $urandom_range(1) ? 4096 : -4096;
      default: base = $urandom_range(1) ? (1 << 23) : -(1 << 23);
    endcase
    return 32'(base + int'($urandom_range(40)) - 20);
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_kind = 2'd0; in_value = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    @(posedge clk); #1;
    run = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_field", longint'(out_field), 0);
    chk("reset_fit", longint'(out_fit), 0);
    chk("reset_kind", longint'(out_kind), 0);
    send(2'd0, 32'hFF800000);
    send(2'd1, 32'h00000800);
    send(2'd2, 32'hFFFFFF80);
    idle(3);
    send(2'd0, 32'h00800000);
    send(2'd1, 32'h00001000);
    send(2'd2, 32'h00000100);
    send(2'd3, $urandom);
    idle(3);
    chk("cnt_after_misfits", longint'(misfit_cnt), 4);
    out_ready = 1'b0;
    send(2'd0, 32'h00000011);
    send(2'd1, 32'hFFFFF222);
    in_valid = 1'b1; in_kind = 2'd2; in_value = 32'h00000033;
    repeat (3) step();
    chk("in_ready_stalled", longint'(in_ready), 0);
    out_ready = 1'b1;
    send(2'd2, 32'h00000033);
    idle(4);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    repeat (CMAX - 1) send(2'd3, 32'h0);
    idle(2);
    chk("cnt_preload", longint'(misfit_cnt), CMAX - 1);
    repeat (3) send(2'd2, 32'h00001000);
    idle(2);
    chk("cnt_saturated", longint'(misfit_cnt), CMAX);
    cnt_clr = 1'b1;
    send(2'd1, 32'h00010000);
    cnt_clr = 1'b0;
    idle(1);
    chk("cnt_clr_wins", longint'(misfit_cnt), 0);
    out_ready = 1'b0;
    send(2'd0, 32'h40000000);
    send(2'd0, 32'h40000001);
    in_valid = 1'b0;
    chk("full_before_reset", longint'(in_ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_misfit_cnt", longint'(misfit_cnt), 0);
    out_ready = 1'b1;
    idle(5);
    soak = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) idle(1);
      send(2'($urandom_range(3)), rand_value());
    end
    soak = 0;
    out_ready = 1'b1;
    idle(10);
    chk("drained", longint'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_pack.md
Name: imm_pack

Overview:
- Inverse of the pipeline's immediate sign-extension stage. Takes a 32-bit signed value plus a field kind (branch, load/store, ALU) and packs it into the 24-bit instruction immediate field.
- Flags whether the value survives the round trip through the decode-side extension.
- Sits in the instruction-image builder / program loader path, ahead of instruction-memory writes.
- Streams with valid/ready and a skid buffer; keeps a saturating count of values that do not fit.

Parameters:
- CNT_W, 16, width of the misfit counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat; driven from a register only
- in_kind  in  2  0=branch, 1=load/store, 2=ALU, 3=reserved
- in_value  in  32  signed value to pack
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts the beat
- out_field  out  24  packed immediate field
- out_fit  out  1  1 = value round-trips exactly
- out_kind  out  2  echo of in_kind
- cnt_clr  in  1  synchronous clear of misfit_cnt
- misfit_cnt  out  CNT_W  saturating count of accepted beats with fit=0

Behaviour:
- Reset:
  - out_valid=0, out_field=0, out_fit=0, out_kind=0.
  - misfit_cnt=0, skid empty, in_ready=1.
  - Reset mid-transfer discards both held beats.
- Pack rules, with s = in_value[31]:
  - branch: field = value[23:0]; fit iff value[31:23] all equal.
  - load/store: field = {12{s}, value[11:0]}; fit iff value[31:12] all equal. Bit 11 is free data.
  - ALU: field = {16{s}, value[7:0]}; fit iff value[31:8] all equal.
  - reserved: field = 0, fit = 0.
  - Field is always produced, even when fit=0 (truncated).
  - Invariant: when fit=1, re-extending field by kind yields in_value exactly.
- Pack logic is combinational on the input beat. The result is registered, with no other input-to-output combinational path.
- Handshake:
  - Beat accepted on an edge with in_valid & in_ready.
  - Beat delivered on an edge with out_valid & out_ready.
  - out_* held stable while out_valid & !out_ready.
- Latency: 1 cycle from acceptance to out_valid when the output register is free or drains on the same edge.
- Buffering: output register plus one skid register, 2 beats total.
  - Accept while the output is stalled: the beat goes to skid and in_ready drops to 0 on the next cycle.
  - Output drains with skid full: skid moves to output, in_ready returns to 1.
  - Output drains and a new beat is accepted on the same edge: the new beat goes straight to output. Full throughput is 1 beat/cycle.
  - in_ready = !skid_full, registered.
- Order is preserved; no beat is dropped or duplicated.
- Counter:
  - Increments on acceptance of a beat with fit=0.
  - Saturates at 2^CNT_W-1, no wrap.
  - cnt_clr wins over a simultaneous increment: the result is 0 and that beat is not counted.
- in_value/in_kind are ignored when in_valid=0.

Decomposition:
- Shared package holds:
  - kind constants KIND_BR=0, KIND_LS=1, KIND_ALU=2, KIND_RSV=3
  - field widths 24/12/8 and the 24-bit field width constant
- These constants are also consumed by the sign-extension stage, so encoder and decoder use one definition.
- One sub-module is natural: imm_pack_core, purely combinational (kind, value) -> (field, fit). The decode-side extension checks against it as its reference.
- The top level handles the handshake, skid and counter.

Test Plan:
- After reset, stream 3 beats with out_ready=1, expect 1 beat/cycle output with latency 1:
  - branch 0xFF800000 -> field 0x800000, fit 1
  - load/store 0x00000800 -> field 0x000800, fit 1
  - ALU 0xFFFFFF80 -> field 0xFFFF80, fit 1
- Misfits, then misfit_cnt=4 (the reserved beat counts):
  - branch 0x00800000 -> field 0x800000, fit 0
  - load/store 0x00001000 -> field 0x000000, fit 0
  - ALU 0x00000100 -> fit 0
  - reserved kind with any value -> field 0, fit 0
- Backpressure:
  - Hold out_ready=0, offer 3 beats: 2 accepted, in_ready=0 from the cycle after the 2nd acceptance.
  - Release: beats emerge in order, out_* stable while stalled.
- Counter edges:
  - Preload 0xFFFE, send 3 misfits -> misfit_cnt sticks at 0xFFFF.
  - Assert cnt_clr on the same cycle as a misfit acceptance -> misfit_cnt=0.
- Assert rst with both stages full -> next cycle out_valid=0, in_ready=1, misfit_cnt=0, and no stale beat later.
- Random soak, 10k beats with random kind/value/ready:
  - scoreboard checks that fit=1 implies re-extension equals in_value
  - order and count preserved
